// File: rtl/execute_stage.sv
// Execute stage of the 5-stage RV64 core: ALU, branch resolution and an iterative
// shift-add multiplier feeding the EXE->MEM latch, with back-pressure to decode.
module execute_stage #(
  parameter int MUL_BITS = 4
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        EXE_V,
  input  logic [31:0] EXE_IR,
  input  logic [63:0] EXE_NPC,
  input  logic [63:0] ALU1,
  input  logic [63:0] ALU2,
  input  logic [63:0] TARGET_ADDRESS,
  input  logic [63:0] MEM_ADDRESS,
  input  logic        MEM_STALL,
  output logic        EXE_BUSY,
  output logic [4:0]  EXE_DR,
  output logic        BR_TAKEN,
  output logic [63:0] BR_TARGET,
  output logic        MEM_V,
  output logic [31:0] MEM_IR,
  output logic [63:0] MEM_RESULT,
  output logic [63:0] MEM_ADDR,
  output logic [63:0] MEM_STORE_DATA
);

  localparam int MUL_ITER = 64 / MUL_BITS;
  localparam int CNT_W    = $clog2(MUL_ITER + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  logic [1:0]       state_q, state_d;
  logic             mem_v_q, mem_v_d;
  logic [31:0]      mem_ir_q, mem_ir_d;
  logic [63:0]      mem_res_q, mem_res_d;
  logic [63:0]      mem_addr_q, mem_addr_d;
  logic [63:0]      mem_sd_q, mem_sd_d;
  logic             br_q, br_d;
  logic [63:0]      br_tgt_q, br_tgt_d;
  logic [4:0]       dr_q, dr_d;
  logic [63:0]      mcand_q, mcand_d;
  logic [63:0]      mplier_q, mplier_d;
  logic [63:0]      acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      mul_ir_q, mul_ir_d;

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [4:0] rd;
  assign opc = EXE_IR[6:0];
  assign rd  = EXE_IR[11:7];
  assign f3  = EXE_IR[14:12];
  assign f7  = EXE_IR[31:25];

  // rs1/rs2 specifiers are resolved by decode; operands arrive already read
  logic unused_rs1;
  assign unused_rs1 = ^EXE_IR[19:15];

  function automatic logic [63:0] alu_op(input logic [2:0] fn, input logic alt,
                                         input logic [63:0] a, input logic [63:0] b);
    logic signed [63:0] sa, sb, sra;
    logic [5:0]         sh;
    sa  = a;
    sb  = b;
    sh  = b[5:0];
    sra = sa >>> sh;
    case (fn)
      3'b000:  alu_op = alt ? (a - b) : (a + b);
      3'b001:  alu_op = a << sh;
      3'b010:  alu_op = {63'd0, (sa < sb)};
      3'b011:  alu_op = {63'd0, (a < b)};
      3'b100:  alu_op = a ^ b;
      3'b101:  if (alt) alu_op = sra; else alu_op = a >> sh;
      3'b110:  alu_op = a | b;
      default: alu_op = a & b;
    endcase
  endfunction

  logic signed [63:0] op1_s, op2_s;
  assign op1_s = ALU1;
  assign op2_s = ALU2;

  logic        dec_ok, dec_mul, dec_rd_en, dec_taken;
  logic [63:0] dec_res, dec_addr, dec_sd, dec_tgt;

  always_comb begin
    dec_ok    = 1'b0;
    dec_mul   = 1'b0;
    dec_rd_en = 1'b0;
    dec_taken = 1'b0;
    dec_res   = '0;
    dec_addr  = '0;
    dec_sd    = '0;
    dec_tgt   = '0;
    case (opc)
      OPC_OP: begin
        // funct7=0000001 selects M-extension; only MUL itself is implemented
        if (f7 == 7'b0000001) begin
          dec_mul   = (f3 == 3'b000);
          dec_rd_en = (f3 == 3'b000);
        end else begin
          dec_ok    = 1'b1;
          dec_rd_en = 1'b1;
          dec_res   = alu_op(f3, f7[5], ALU1, ALU2);
        end
      end
      OPC_OPIMM: begin
        dec_ok    = 1'b1;
        dec_rd_en = 1'b1;
        dec_res   = alu_op(f3, (f3 == 3'b101) & EXE_IR[30], ALU1, ALU2);
      end
      OPC_LUI: begin
        dec_ok    = 1'b1;
        dec_rd_en = 1'b1;
        dec_res   = ALU1;
      end
      OPC_AUIPC: begin
        dec_ok    = 1'b1;
        dec_rd_en = 1'b1;
        dec_res   = EXE_NPC - 64'd4 + ALU1;
      end
      OPC_LOAD: begin
        dec_ok    = 1'b1;
        dec_rd_en = 1'b1;
        dec_addr  = MEM_ADDRESS;
      end
      OPC_STORE: begin
        dec_ok   = 1'b1;
        dec_addr = MEM_ADDRESS;
        dec_sd   = ALU2;
      end
      OPC_BRANCH: begin
        dec_tgt = TARGET_ADDRESS;
        dec_ok  = 1'b1;
        case (f3)
          3'b000:  dec_taken = (ALU1 == ALU2);
          3'b001:  dec_taken = (ALU1 != ALU2);
          3'b100:  dec_taken = (op1_s < op2_s);
          3'b101:  dec_taken = !(op1_s < op2_s);
          3'b110:  dec_taken = (ALU1 < ALU2);
          3'b111:  dec_taken = !(ALU1 < ALU2);
          default: dec_ok    = 1'b0;
        endcase
      end
      OPC_JAL: begin
        dec_ok    = 1'b1;
        dec_rd_en = 1'b1;
        dec_res   = EXE_NPC;
        dec_taken = 1'b1;
        dec_tgt   = TARGET_ADDRESS;
      end
      OPC_JALR: begin
        dec_ok    = 1'b1;
        dec_rd_en = 1'b1;
        dec_res   = EXE_NPC;
        dec_taken = 1'b1;
        dec_tgt   = (ALU1 + {{52{EXE_IR[31]}}, EXE_IR[31:20]}) & ~64'd1;
      end
      default: ;
    endcase
  end

  logic [63:0] mul_partial, acc_next, product;
  logic        in_mul, mul_last, mul_done, mul_fin;

  // One shift-add step: MUL_BITS multiplier bits folded into the accumulator
  always_comb begin
    mul_partial = '0;
    for (int i = 0; i < MUL_BITS; i++) begin
      if (mplier_q[i]) mul_partial = mul_partial + (mcand_q << i);
    end
    acc_next = acc_q + mul_partial;
  end

  assign in_mul   = (state_q == S_MUL);
  assign mul_last = in_mul && (cnt_q == CNT_W'(MUL_ITER - 1));
  assign mul_done = in_mul && (cnt_q == CNT_W'(MUL_ITER));
  assign mul_fin  = mul_last | mul_done;
  assign product  = mul_done ? acc_q : acc_next;

  logic hold, accept;
  assign hold     = mem_v_q & MEM_STALL;
  assign EXE_BUSY = in_mul | hold;
  assign accept   = EXE_V & ~EXE_BUSY;

  always_comb begin
    state_d    = state_q;
    mem_v_d    = mem_v_q;
    mem_ir_d   = mem_ir_q;
    mem_res_d  = mem_res_q;
    mem_addr_d = mem_addr_q;
    mem_sd_d   = mem_sd_q;
    br_d       = 1'b0;
    br_tgt_d   = '0;
    dr_d       = dr_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    mul_ir_d   = mul_ir_q;

    // Iteration keeps running even while the latch is held; it parks once done
    if (in_mul && !mul_done) begin
      acc_d    = acc_next;
      mcand_d  = mcand_q << MUL_BITS;
      mplier_d = mplier_q >> MUL_BITS;
      cnt_d    = cnt_q + 1'b1;
    end

    if (hold) begin
      state_d = in_mul ? S_MUL : S_HOLD;
      if (!in_mul) dr_d = '0;
    end else if (in_mul) begin
      if (mul_fin) begin
        mem_v_d    = 1'b1;
        mem_ir_d   = mul_ir_q;
        mem_res_d  = product;
        mem_addr_d = '0;
        mem_sd_d   = '0;
        dr_d       = '0;
        state_d    = S_IDLE;
      end else begin
        mem_v_d = 1'b0;
      end
    end else if (accept) begin
      state_d = S_IDLE;
      dr_d    = dec_rd_en ? rd : 5'd0;
      if (dec_mul) begin
        state_d  = S_MUL;
        mem_v_d  = 1'b0;
        mcand_d  = ALU1;
        mplier_d = ALU2;
        acc_d    = '0;
        cnt_d    = '0;
        mul_ir_d = EXE_IR;
      end else if (dec_ok) begin
        mem_v_d    = 1'b1;
        mem_ir_d   = EXE_IR;
        mem_res_d  = dec_res;
        mem_addr_d = dec_addr;
        mem_sd_d   = dec_sd;
        br_d       = dec_taken;
        br_tgt_d   = dec_taken ? dec_tgt : 64'd0;
      end else begin
        mem_v_d = 1'b0;
        dr_d    = '0;
      end
    end else begin
      state_d = S_IDLE;
      mem_v_d = 1'b0;
      dr_d    = '0;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= S_IDLE;
      mem_v_q    <= 1'b0;
      mem_ir_q   <= '0;
      mem_res_q  <= '0;
      mem_addr_q <= '0;
      mem_sd_q   <= '0;
      br_q       <= 1'b0;
      br_tgt_q   <= '0;
      dr_q       <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      mul_ir_q   <= '0;
    end else begin
      state_q    <= state_d;
      mem_v_q    <= mem_v_d;
      mem_ir_q   <= mem_ir_d;
      mem_res_q  <= mem_res_d;
      mem_addr_q <= mem_addr_d;
      mem_sd_q   <= mem_sd_d;
      br_q       <= br_d;
      br_tgt_q   <= br_tgt_d;
      dr_q       <= dr_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      mul_ir_q   <= mul_ir_d;
    end
  end

  assign EXE_DR         = dr_q;
  assign BR_TAKEN       = br_q;
  assign BR_TARGET      = br_tgt_q;
  assign MEM_V          = mem_v_q;
  assign MEM_IR         = mem_ir_q;
  assign MEM_RESULT     = mem_res_q;
  assign MEM_ADDR       = mem_addr_q;
  assign MEM_STORE_DATA = mem_sd_q;

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed scenarios plus randomized bundles/stalls compared
// against a transaction-level reference model.
module tb_execute_stage;

  localparam int MB   = 4;
  localparam int ITER = 64 / MB;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        EXE_V;
  logic [31:0] EXE_IR;
  logic [63:0] EXE_NPC, ALU1, ALU2, TARGET_ADDRESS, MEM_ADDRESS;
  logic        MEM_STALL;
  logic        EXE_BUSY, BR_TAKEN, MEM_V;
  logic [4:0]  EXE_DR;
  logic [63:0] BR_TARGET, MEM_RESULT, MEM_ADDR, MEM_STORE_DATA;
  logic [31:0] MEM_IR;

  always #5 CLK = ~CLK;

  execute_stage #(.MUL_BITS(MB)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .EXE_V(EXE_V), .EXE_IR(EXE_IR), .EXE_NPC(EXE_NPC),
    .ALU1(ALU1), .ALU2(ALU2), .TARGET_ADDRESS(TARGET_ADDRESS), .MEM_ADDRESS(MEM_ADDRESS),
    .MEM_STALL(MEM_STALL), .EXE_BUSY(EXE_BUSY), .EXE_DR(EXE_DR), .BR_TAKEN(BR_TAKEN),
    .BR_TARGET(BR_TARGET), .MEM_V(MEM_V), .MEM_IR(MEM_IR), .MEM_RESULT(MEM_RESULT),
    .MEM_ADDR(MEM_ADDR), .MEM_STORE_DATA(MEM_STORE_DATA)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic        ok;
    logic        is_mul;
    logic [4:0]  rd;
    logic [63:0] res;
    logic [63:0] addr;
    logic [63:0] sd;
    logic        br;
    logic [63:0] brt;
  } dec_t;

  function automatic logic [63:0] ref_alu(input logic [2:0] fn, input logic alt,
                                          input logic [63:0] a, input logic [63:0] b);
    logic signed [63:0] sa, sb, sra;
    int sh;
    sa = a; sb = b; sh = int'(b[5:0]);
    sra = sa >>> sh;
    case (fn)
      3'd0: return alt ? a - b : a + b;
      3'd1: return a << sh;
      3'd2: return (sa < sb) ? 64'd1 : 64'd0;
      3'd3: return (a < b) ? 64'd1 : 64'd0;
      3'd4: return a ^ b;
      3'd5: begin if (alt) return sra; return a >> sh; end
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic dec_t ref_dec(input logic [31:0] ir, input logic [63:0] a, input logic [63:0] b,
                                   input logic [63:0] npc, input logic [63:0] tgt, input logic [63:0] maddr);
    dec_t d;
    logic signed [63:0] sa, sb;
    logic [2:0] fn;
    d = '0; sa = a; sb = b; fn = ir[14:12];
    case (ir[6:0])
      7'h33: begin
        if (ir[31:25] == 7'h01) begin
          if (fn == 3'd0) begin d.is_mul = 1; d.rd = ir[11:7]; d.res = a * b; end
        end else begin d.ok = 1; d.rd = ir[11:7]; d.res = ref_alu(fn, ir[30], a, b); end
      end
      7'h13: begin d.ok = 1; d.rd = ir[11:7]; d.res = ref_alu(fn, fn == 3'd5 && ir[30], a, b); end
      7'h37: begin d.ok = 1; d.rd = ir[11:7]; d.res = a; end
      7'h17: begin d.ok = 1; d.rd = ir[11:7]; d.res = npc - 4 + a; end
      7'h03: begin d.ok = 1; d.rd = ir[11:7]; d.addr = maddr; end
      7'h23: begin d.ok = 1; d.addr = maddr; d.sd = b; end
      7'h63: begin
        d.ok = 1;
        case (fn)
          3'd0: d.br = (a == b);
          3'd1: d.br = (a != b);
          3'd4: d.br = (sa < sb);
          3'd5: d.br = (sa >= sb);
          3'd6: d.br = (a < b);
          3'd7: d.br = (a >= b);
          default: d.ok = 0;
        endcase
        if (d.br) d.brt = tgt;
      end
      7'h6f: begin d.ok = 1; d.rd = ir[11:7]; d.res = npc; d.br = 1; d.brt = tgt; end
      7'h67: begin
        d.ok = 1; d.rd = ir[11:7]; d.res = npc; d.br = 1;
        d.brt = (a + {{52{ir[31]}}, ir[31:20]}) & ~64'd1;
      end
      default: ;
    endcase
    return d;
  endfunction

  // Reference state: what the latch/outputs should hold, and a multiply in flight
  logic        m_mem_v, m_br, m_in_mul;
  logic [31:0] m_ir, m_mir;
  logic [63:0] m_res, m_addr, m_sd, m_brt, m_prod;
  logic [4:0]  m_dr;
  int          m_mcyc;

  task automatic model_reset();
    m_mem_v = 0; m_br = 0; m_in_mul = 0; m_ir = 0; m_mir = 0; m_res = 0;
    m_addr = 0; m_sd = 0; m_brt = 0; m_prod = 0; m_dr = 0; m_mcyc = 0;
  endtask

  task automatic model_edge();
    dec_t d;
    logic hold;
    hold = m_mem_v && MEM_STALL;
    m_br = 0; m_brt = 0;
    if (hold) begin
      if (m_in_mul) m_mcyc++; else m_dr = 0;
    end else if (m_in_mul) begin
      m_mcyc++;
      if (m_mcyc >= ITER) begin
        m_mem_v = 1; m_ir = m_mir; m_res = m_prod; m_addr = 0; m_sd = 0;
        m_in_mul = 0; m_dr = 0;
      end else m_mem_v = 0;
    end else if (EXE_V) begin
      d = ref_dec(EXE_IR, ALU1, ALU2, EXE_NPC, TARGET_ADDRESS, MEM_ADDRESS);
      m_dr = d.rd;
      if (d.is_mul) begin
        m_in_mul = 1; m_mcyc = 0; m_prod = d.res; m_mir = EXE_IR; m_mem_v = 0;
      end else if (d.ok) begin
        m_mem_v = 1; m_ir = EXE_IR; m_res = d.res; m_addr = d.addr; m_sd = d.sd;
        m_br = d.br; m_brt = d.brt;
      end else begin
        m_mem_v = 0; m_dr = 0;
      end
    end else begin
      m_mem_v = 0; m_dr = 0;
    end
  endtask

  // Called just after a falling edge with inputs set; returns just after the next one
  task automatic cycle();
    #1;
    check_val("busy", 64'(EXE_BUSY), 64'(m_in_mul || (m_mem_v && MEM_STALL)));
    model_edge();
    @(posedge CLK); #1;
    check_val("mem_v", 64'(MEM_V), 64'(m_mem_v));
    check_val("mem_ir", 64'(MEM_IR), 64'(m_ir));
    check_val("mem_result", MEM_RESULT, m_res);
    check_val("mem_addr", MEM_ADDR, m_addr);
    check_val("mem_store_data", MEM_STORE_DATA, m_sd);
    check_val("br_taken", 64'(BR_TAKEN), 64'(m_br));
    check_val("br_target", BR_TARGET, m_brt);
    check_val("exe_dr", 64'(EXE_DR), 64'(m_dr));
    @(negedge CLK);
  endtask

  task automatic zero_checks(input string p);
    check_val({p, "_busy"}, 64'(EXE_BUSY), 64'd0);
    check_val({p, "_dr"}, 64'(EXE_DR), 64'd0);
    check_val({p, "_br"}, 64'(BR_TAKEN), 64'd0);
    check_val({p, "_brt"}, BR_TARGET, 64'd0);
    check_val({p, "_mem_v"}, 64'(MEM_V), 64'd0);
    check_val({p, "_mem_ir"}, 64'(MEM_IR), 64'd0);
    check_val({p, "_result"}, MEM_RESULT, 64'd0);
    check_val({p, "_addr"}, MEM_ADDR, 64'd0);
    check_val({p, "_sd"}, MEM_STORE_DATA, 64'd0);
  endtask

  task automatic drive(input logic [31:0] ir, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] npc, input logic [63:0] tgt);
    EXE_V = 1; EXE_IR = ir; ALU1 = a; ALU2 = b; EXE_NPC = npc; TARGET_ADDRESS = tgt;
    MEM_ADDRESS = 64'h0;
  endtask

  function automatic logic [31:0] mk_ir(input logic [6:0] f7, input logic [2:0] fn,
                                        input logic [4:0] rd, input logic [6:0] opc);
    return {f7, 10'd0, fn, rd, opc};
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [31:0] rand_ir();
    logic [31:0] r;
    logic [6:0]  opc, f7;
    logic [2:0]  fn;
    r = $urandom; f7 = r[31:25]; fn = r[14:12];
    case ($urandom_range(0, 11))
      0: begin opc = 7'h33; f7 = r[30] ? 7'h20 : 7'h00; end
      1: opc = 7'h13;
      2: opc = 7'h37;
      3: opc = 7'h17;
      4: opc = 7'h03;
      5: opc = 7'h23;
      6, 7: opc = 7'h63;
      8: opc = 7'h6f;
      9: opc = 7'h67;
      10: begin opc = 7'h33; f7 = 7'h01; if (r[0]) fn = 3'd0; end
      default: opc = r[0] ? 7'h3b : 7'h7f;
    endcase
    return {f7, r[24:15], fn, r[11:7], opc};
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    RESET_N = 0; EXE_V = 0; EXE_IR = 0; EXE_NPC = 0; ALU1 = 0; ALU2 = 0;
    TARGET_ADDRESS = 0; MEM_ADDRESS = 0; MEM_STALL = 0;
    model_reset();
    @(negedge CLK); @(negedge CLK);
    zero_checks("rst");
    RESET_N = 1;

    // ADD 5 + (-7), rd=3
    drive(mk_ir(7'h00, 3'd0, 5'd3, 7'h33), 64'd5, -64'sd7, 64'h100, 64'h0);
    cycle();
    check_val("t1_mem_v", 64'(MEM_V), 64'd1);
    check_val("t1_result", MEM_RESULT, 64'hFFFF_FFFF_FFFF_FFFE);
    check_val("t1_dr", 64'(EXE_DR), 64'd3);
    EXE_V = 0; cycle();

    // MUL 7 * (-3), rd=5
    drive(mk_ir(7'h01, 3'd0, 5'd5, 7'h33), 64'd7, -64'sd3, 64'h200, 64'h0);
    cycle();
    EXE_V = 0;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      if (!EXE_BUSY) break;
      n++;
      cycle();
    end
    check_val("t2_busy_cycles", 64'(n), 64'd16);
    check_val("t2_mem_v", 64'(MEM_V), 64'd1);
    check_val("t2_result", MEM_RESULT, -64'sd21);
    cycle();
    check_val("t2_mem_v_drop", 64'(MEM_V), 64'd0);

    // BEQ taken, then BNE not taken
    drive(mk_ir(7'h00, 3'd0, 5'd0, 7'h63), 64'd9, 64'd9, 64'h300, 64'h1000);
    cycle();
    check_val("t3_beq_taken", 64'(BR_TAKEN), 64'd1);
    check_val("t3_beq_target", BR_TARGET, 64'h1000);
    check_val("t3_beq_mem_v", 64'(MEM_V), 64'd1);
    EXE_V = 0; cycle();
    check_val("t3_pulse_end", 64'(BR_TAKEN), 64'd0);
    drive(mk_ir(7'h00, 3'd1, 5'd0, 7'h63), 64'd9, 64'd9, 64'h300, 64'h1000);
    cycle();
    check_val("t3_bne_taken", 64'(BR_TAKEN), 64'd0);

    // JALR 0x2003 + 4, link 0x104
    drive({12'd4, 5'd0, 3'd0, 5'd1, 7'h67}, 64'h2003, 64'd4, 64'h104, 64'h0);
    cycle();
    check_val("t4_target", BR_TARGET, 64'h2006);
    check_val("t4_result", MEM_RESULT, 64'h104);
    check_val("t4_taken", 64'(BR_TAKEN), 64'd1);

    // SUB 10-4 then three stalled cycles with the next bundle waiting
    drive(mk_ir(7'h20, 3'd0, 5'd7, 7'h33), 64'd10, 64'd4, 64'h400, 64'h0);
    cycle();
    drive(mk_ir(7'h00, 3'd0, 5'd9, 7'h33), 64'd100, 64'd23, 64'h404, 64'h0);
    MEM_STALL = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check_val("t5_busy", 64'(EXE_BUSY), 64'd1);
      check_val("t5_held", MEM_RESULT, 64'd6);
      cycle();
    end
    MEM_STALL = 0;
    cycle();
    check_val("t5_next_result", MEM_RESULT, 64'd123);
    check_val("t5_next_dr", 64'(EXE_DR), 64'd9);

    // Reset during the fifth MUL cycle
    drive(mk_ir(7'h01, 3'd0, 5'd4, 7'h33), 64'd11, 64'd13, 64'h500, 64'h0);
    cycle();
    EXE_V = 0;
    for (int k = 0; k < 4; k++) cycle();
    RESET_N = 0;
    #1;
    zero_checks("t6");
    model_reset();
    @(negedge CLK); @(negedge CLK);
    RESET_N = 1;
    for (int k = 0; k < 20; k++) begin
      cycle();
      check_val("t6_no_mem_v", 64'(MEM_V), 64'd0);
    end

    // Randomized bundles with random stalls
    for (int i = 0; i < 900; i++) begin
      EXE_V = ($urandom_range(0, 9) < 7);
      MEM_STALL = ($urandom_range(0, 3) == 0);
      EXE_IR = rand_ir();
      ALU1 = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 20)) : rand64();
      ALU2 = ($urandom_range(0, 2) == 0) ? ALU1 : rand64();
      if ($urandom_range(0, 3) == 0) ALU2 = 64'($urandom_range(0, 70));
      EXE_NPC = rand64();
      TARGET_ADDRESS = rand64();
      MEM_ADDRESS = rand64();
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
